// File: rtl/cache_bus1_slave_if.sv
// CPU-side A1/C1/D1 bus plus cache-core request/response channel.
// C1/D1 are resolved here from the CPU and slave tri-state drivers.
interface cache_bus1_slave_if #(
  parameter int ADDR1_BUS_SIZE  = 15,
  parameter int DATA1_BUS_SIZE  = 16,
  parameter int CTR1_BUS_SIZE   = 3,
  parameter int CACHE_ADDR_SIZE = 20
);
  logic [ADDR1_BUS_SIZE-1:0]  A1;
  wire  [CTR1_BUS_SIZE-1:0]   C1;
  wire  [DATA1_BUS_SIZE-1:0]  D1;

  logic [CTR1_BUS_SIZE-1:0]   m_c1_dat;
  logic                       m_c1_oe;
  logic [DATA1_BUS_SIZE-1:0]  m_d1_dat;
  logic                       m_d1_oe;

  logic [CTR1_BUS_SIZE-1:0]   s_c1_dat;
  logic                       s_c1_oe;
  logic [DATA1_BUS_SIZE-1:0]  s_d1_dat;
  logic                       s_d1_oe;

  logic                       req_valid;
  logic                       req_ready;
  logic [CTR1_BUS_SIZE-1:0]   req_cmd;
  logic [CACHE_ADDR_SIZE-1:0] req_addr;
  logic [31:0]                req_wdata;
  logic                       resp_valid;
  logic [31:0]                resp_rdata;
  logic                       busy;

  assign C1 = s_c1_oe ? s_c1_dat : 'z;
  assign C1 = m_c1_oe ? m_c1_dat : 'z;
  assign D1 = s_d1_oe ? s_d1_dat : 'z;
  assign D1 = m_d1_oe ? m_d1_dat : 'z;

  modport slave (
    input  A1, C1, D1, req_ready, resp_valid, resp_rdata,
    output s_c1_dat, s_c1_oe, s_d1_dat, s_d1_oe,
    output req_valid, req_cmd, req_addr, req_wdata, busy
  );

  modport master (
    output A1, m_c1_dat, m_c1_oe, m_d1_dat, m_d1_oe, req_ready, resp_valid, resp_rdata,
    input  C1, D1, req_valid, req_cmd, req_addr, req_wdata, busy
  );
endinterface

// File: rtl/cache_bus1_slave.sv
// Bus-1 slave: two-word CPU command capture -> cache core request -> 1/2-beat response.
// Min latency cmd->RESP0 is 4 edges; req_valid holds until req_ready, no new cmd while busy.
module cache_bus1_slave #(
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA1_BUS_SIZE    = 16,
  parameter int CTR1_BUS_SIZE     = 3,
  parameter int CACHE_OFFSET_SIZE = 5,
  parameter int CACHE_ADDR_SIZE   = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  cache_bus1_slave_if.slave   bus
);
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_RD8  = 3'd1;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_RD16 = 3'd2;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_RD32 = 3'd3;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_WR8  = 3'd5;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_WR32 = 3'd7;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_REQ,
    S_WAIT,
    S_RESP0,
    S_RESP1
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [CTR1_BUS_SIZE-1:0]     r_cmd;
  logic [CACHE_ADDR_SIZE-1:0]   r_addr;
  logic [31:0]                  r_wdata;
  logic [31:0]                  r_rdata;

  logic                         w_cmd_vld;
  logic                         w_c1_oe;
  logic                         w_d1_oe;
  logic [DATA1_BUS_SIZE-1:0]    w_d1_dat;

  // Floating or unknown C1 must never start a transaction.
  assign w_cmd_vld = !$isunknown(bus.C1) && (bus.C1 != '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_c1_oe  = 1'b0;
    w_d1_oe  = 1'b0;
    w_d1_dat = '0;
    case (r_state)
      S_IDLE:  if (w_cmd_vld) w_next = S_ADDR2;
      S_ADDR2: w_next = S_REQ;
      S_REQ:   if (bus.req_ready) w_next = S_WAIT;
      S_WAIT:  if (bus.resp_valid) w_next = S_RESP0;
      S_RESP0: begin
        w_c1_oe = 1'b1;
        w_next  = (r_cmd == CMD_RD32) ? S_RESP1 : S_IDLE;
        if (r_cmd == CMD_RD8) begin
          w_d1_oe  = 1'b1;
          w_d1_dat = DATA1_BUS_SIZE'(r_rdata[7:0]);
        end else if (r_cmd == CMD_RD16 || r_cmd == CMD_RD32) begin
          w_d1_oe  = 1'b1;
          w_d1_dat = r_rdata[DATA1_BUS_SIZE-1:0];
        end
      end
      S_RESP1: begin
        w_c1_oe  = 1'b1;
        w_d1_oe  = 1'b1;
        w_d1_dat = r_rdata[31:32-DATA1_BUS_SIZE];
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cmd   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_vld) begin
            r_cmd   <= bus.C1;
            r_addr  <= {bus.A1, {CACHE_OFFSET_SIZE{1'b0}}};
            r_wdata <= 32'(bus.D1);
          end
        end
        S_ADDR2: begin
          r_addr[CACHE_OFFSET_SIZE-1:0] <= bus.A1[CACHE_OFFSET_SIZE-1:0];
          if (r_cmd == CMD_WR32) begin
            r_wdata[31:32-DATA1_BUS_SIZE] <= bus.D1;
          end else if (r_cmd == CMD_WR8) begin
            r_wdata[31:8] <= '0;
          end
        end
        S_WAIT: begin
          if (bus.resp_valid) r_rdata <= bus.resp_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_valid = (r_state == S_REQ);
  assign bus.req_cmd   = r_cmd;
  assign bus.req_addr  = r_addr;
  assign bus.req_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.s_c1_oe   = w_c1_oe;
  assign bus.s_c1_dat  = C1_RESP;
  assign bus.s_d1_oe   = w_d1_oe;
  assign bus.s_d1_dat  = w_d1_dat;
endmodule

// File: doc/cache_bus1_slave.md
CACHE_BUS1_SLAVE -- requirements
Module: cache_bus1_slave

Interface
REQ-001 Parameter ADDR1_BUS_SIZE, default 15, width of A1 (tag+set part of address).
REQ-002 Parameter DATA1_BUS_SIZE, default 16, width of D1.
REQ-003 Parameter CTR1_BUS_SIZE, default 3, width of C1.
REQ-004 Parameter CACHE_OFFSET_SIZE, default 5, offset bits carried in the second A1 word.
REQ-005 Parameter CACHE_ADDR_SIZE, default 20, full byte address width = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE.
REQ-006 CLK  input  1  single clock; all state changes on posedge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 A1  input  ADDR1_BUS_SIZE  CPU address bus (word 1 = addr>>5, word 2 = addr offset).
REQ-009 C1  inout  CTR1_BUS_SIZE  command/response bus; 0 NOP, 1 RD8, 2 RD16, 3 RD32, 4 INVAL, 5 WR8, 6 WR16, 7 WR32 from CPU; 7 RESPONSE from this block.
REQ-010 D1  inout  DATA1_BUS_SIZE  data bus, shared both directions.
REQ-011 req_valid  output  1  request to cache core pending.
REQ-012 req_ready  input  1  cache core accepts request this cycle.
REQ-013 req_cmd  output  3  captured command code (1..7).
REQ-014 req_addr  output  CACHE_ADDR_SIZE  assembled byte address.
REQ-015 req_wdata  output  32  write data, zero-extended for WR8/WR16.
REQ-016 resp_valid  input  1  one-cycle pulse: cache core finished request.
REQ-017 resp_rdata  input  32  read data, valid with resp_valid.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ADDR2, REQ, WAIT, RESP0, RESP1.
REQ-020 IDLE: on posedge with C1 in 1..7 (no X/Z bits), latch cmd, A1 as addr[19:5], D1 as wdata[15:0]; go ADDR2; C1 = 0, X or Z is ignored.
REQ-021 ADDR2: latch A1[4:0] as addr[4:0]; for WR32 latch D1 as wdata[31:16]; for WR8 keep only wdata[7:0]; go REQ.
REQ-022 REQ: req_valid=1 with stable cmd/addr/wdata; on req_ready=1 go WAIT; req_valid held until accepted.
REQ-023 WAIT: on resp_valid=1 latch resp_rdata; go RESP0; resp_valid in any other state SHALL be ignored.
REQ-024 RESP0: drive C1=7; drive D1 = rdata[7:0] zero-extended (RD8), rdata[15:0] (RD16, RD32), Z otherwise; go RESP1 if RD32 else IDLE.
REQ-025 RESP1: drive C1=7, D1 = rdata[31:16]; go IDLE.
REQ-026 C1 and D1 SHALL be Z in every state except RESP0/RESP1 (bus turnaround; CPU releases before first RESP0 edge).
REQ-027 Minimum latency: command seen at posedge N, req_valid high from N+2, RESP0 earliest at N+4 with req_ready and resp_valid each immediate.
REQ-028 New commands SHALL not be sampled while busy=1; C1=0 driven by CPU after response returns block to IDLE with no action.
REQ-029 INVAL, WR8, WR16, WR32 SHALL respond with exactly one RESP0 cycle; RD32 with exactly two.

Reset
REQ-030 RESET=1 SHALL immediately force IDLE, req_valid=0, busy=0, C1=Z, D1=Z, req_cmd=0, req_addr=0, req_wdata=0.
REQ-031 Reset mid-transaction SHALL abandon the request; no response is ever driven for it.
REQ-032 Operation resumes on first posedge after RESET deasserts.

Verification
REQ-033 RD8 addr 0x00045, core returns 0x12345678 -> req_addr=0x00045, req_cmd=1, C1=7 one cycle, D1=0x0078.
REQ-034 RD32 addr 0x01020, rdata 0xDEADBEEF -> C1=7 two cycles, D1=0xBEEF then 0xDEAD, then C1/D1 Z.
REQ-035 WR32 addr 0x0F004, D1 0x5678 then 0x1234 -> req_wdata=0x12345678, req_cmd=7, single C1=7 cycle, D1 Z.
REQ-036 WR8 with D1=0xABCD, req_ready low 5 cycles -> req_valid held 6 cycles, req_wdata=0x000000CD, fields stable.
REQ-037 RESET pulsed in WAIT of RD16 -> C1/D1 Z, busy=0; later resp_valid ignored; next RD16 completes normally.
REQ-038 C1=Z/X and C1=0 in IDLE for 10 cycles -> no req_valid, busy stays 0.
